// File: rtl/blink_multi.sv
`default_nettype none
// ============================================================================
// Module     : blink_multi
// Description: Multi-channel LED blinker: one shared prescaler drives NCH
//              independent off/solid/blink/burst channels.
//              Define BLINK_MULTI_PROPS_EN to compile in the embedded
//              safety/liveness assertions.
// Revision   : 1.0 - initial release
// ============================================================================
module blink_multi #(
    parameter int CBITS = 17,
    parameter int NCH   = 4,
    parameter int BURST = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [NCH-1:0]   en,
    input  logic [2*NCH-1:0] mode_sel,
    output logic [NCH-1:0]   led,
    output logic             flg,
    output logic [NCH-1:0]   phase
);

    localparam int PW = $clog2(BURST + 1);

    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_ON   = 2'd1;
    localparam logic [1:0] c_ST_OFF  = 2'd2;
    localparam logic [1:0] c_ST_GAP  = 2'd3;

    localparam logic [1:0] c_MODE_OFF   = 2'b00;
    localparam logic [1:0] c_MODE_SOLID = 2'b01;
    localparam logic [1:0] c_MODE_BLINK = 2'b10;
    localparam logic [1:0] c_MODE_BURST = 2'b11;

    localparam logic [PW-1:0] c_BURST = PW'(BURST);

    logic [CBITS-1:0] r_cnt;
    logic             r_flg;
    logic             r_armed;
    logic             w_tick;

    assign w_tick = (r_cnt == '0);
    assign flg    = r_flg;

    // r_armed suppresses mode-change detection on the first edge after reset,
    // so a mode set up while in reset starts on the very first tick.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt   <= '0;
            r_flg   <= 1'b0;
            r_armed <= 1'b0;
        end else begin
            r_cnt   <= r_cnt + 1'b1;
            r_flg   <= w_tick;
            r_armed <= 1'b1;
        end
    end

    for (genvar i = 0; i < NCH; i++) begin : g_ch
        logic [1:0]    w_mode;
        logic [1:0]    r_mode_prev;
        logic [1:0]    r_state;
        logic [1:0]    w_state_nxt;
        logic [PW-1:0] r_pcnt;
        logic [PW-1:0] w_pcnt_nxt;
        logic          r_phase;
        logic          w_phase_nxt;
        logic          r_led;
        logic          w_chg;

        assign w_mode   = mode_sel[2*i+1 -: 2];
        assign w_chg    = r_armed && (w_mode != r_mode_prev);
        assign phase[i] = r_phase;
        assign led[i]   = r_led;

        always_comb begin
            w_state_nxt = r_state;
            w_pcnt_nxt  = r_pcnt;
            w_phase_nxt = r_phase;
            if (!en[i]) begin
                w_state_nxt = c_ST_IDLE;
                w_pcnt_nxt  = '0;
                w_phase_nxt = 1'b0;
            end else if (w_chg) begin
                // Old mode's pending tick is dropped; new mode begins next tick.
                w_state_nxt = c_ST_IDLE;
                w_pcnt_nxt  = '0;
                w_phase_nxt = (w_mode == c_MODE_SOLID);
            end else begin
                case (w_mode)
                    c_MODE_OFF: begin
                        w_state_nxt = c_ST_IDLE;
                        w_pcnt_nxt  = '0;
                        w_phase_nxt = 1'b0;
                    end
                    c_MODE_SOLID: begin
                        w_state_nxt = c_ST_IDLE;
                        w_pcnt_nxt  = '0;
                        w_phase_nxt = 1'b1;
                    end
                    c_MODE_BLINK: begin
                        w_pcnt_nxt = '0;
                        if (w_tick) begin
                            w_state_nxt = (r_state == c_ST_ON) ? c_ST_OFF : c_ST_ON;
                        end
                        w_phase_nxt = (w_state_nxt == c_ST_ON);
                    end
                    default: begin
                        if (w_tick) begin
                            case (r_state)
                                c_ST_IDLE: w_state_nxt = c_ST_ON;
                                c_ST_ON: begin
                                    w_state_nxt = c_ST_OFF;
                                    w_pcnt_nxt  = r_pcnt + 1'b1;
                                end
                                c_ST_OFF: begin
                                    w_state_nxt = (r_pcnt < c_BURST) ? c_ST_ON : c_ST_GAP;
                                end
                                default: begin
                                    w_state_nxt = c_ST_ON;
                                    w_pcnt_nxt  = '0;
                                end
                            endcase
                        end
                        w_phase_nxt = (w_state_nxt == c_ST_ON);
                    end
                endcase
            end
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                r_state     <= c_ST_IDLE;
                r_pcnt      <= '0;
                r_phase     <= 1'b0;
                r_led       <= 1'b0;
                r_mode_prev <= 2'b00;
            end else begin
                r_state     <= w_state_nxt;
                r_pcnt      <= w_pcnt_nxt;
                r_phase     <= w_phase_nxt;
                r_led       <= en[i] & r_phase;
                r_mode_prev <= w_mode;
            end
        end

`ifdef BLINK_MULTI_PROPS_EN
        a_led_until: assert property (@(posedge clk) disable iff (rst)
            led[i] |-> (led[i] s_until !phase[i]));
        a_pcnt_max: assert property (@(posedge clk) disable iff (rst)
            (en[i] && (w_mode == c_MODE_BURST)) |-> (r_pcnt <= c_BURST));
        a_blink_live: assert property (@(posedge clk) disable iff (rst)
            (en[i] && (w_mode == c_MODE_BLINK)) |-> s_eventually led[i]);
`endif
    end

`ifdef BLINK_MULTI_PROPS_EN
    a_flg_single: assert property (@(posedge clk) disable iff (rst)
        flg |=> !flg);
`endif

endmodule
`default_nettype wire

// File: tb/tb_blink_multi.sv
`default_nettype none
// ============================================================================
// Module     : tb_blink_multi
// Description: Directed self-checking bench for blink_multi (CBITS=3, NCH=2,
//              BURST=3).
// Revision   : 1.0 - initial release
// ============================================================================
module tb_blink_multi;

    logic       clk;
    logic       rst;
    logic [1:0] en;
    logic [3:0] mode_sel;
    logic [1:0] led;
    logic       flg;
    logic [1:0] phase;

    int errors = 0;
    int checks = 0;

    blink_multi #(
        .CBITS (3),
        .NCH   (2),
        .BURST (3)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .mode_sel (mode_sel),
        .led      (led),
        .flg      (flg),
        .phase    (phase)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Blink: ON for ticks 0,2,4,... ; one tick = 8 cycles.
    function automatic logic exp_blink(input int n);
        return ((n / 8) % 2) == 0;
    endfunction

    // Burst of 3: ON,OFF,ON,OFF,ON,OFF,GAP repeating every 7 ticks.
    function automatic logic exp_burst(input int n);
        int k;
        k = (n / 8) % 7;
        return (k == 0) || (k == 2) || (k == 4);
    endfunction

    // Sample n is taken at the negedge following the n-th posedge after release.
    task automatic do_reset(input logic [1:0] e, input logic [3:0] m);
        @(negedge clk);
        rst      = 1'b1;
        en       = e;
        mode_sel = m;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; en = 2'b11; mode_sel = 4'b0101;
        repeat (3) @(negedge clk);
        checks++;
        if (led !== 2'b00) begin errors++; $display("FAIL reset_led got=%b exp=00", led); end
        checks++;
        if (phase !== 2'b00) begin errors++; $display("FAIL reset_phase got=%b exp=00", phase); end
        checks++;
        if (flg !== 1'b0) begin errors++; $display("FAIL reset_flg got=%b exp=0", flg); end
    endtask

    task automatic test_prescaler();
        do_reset(2'b00, 4'b0000);
        for (int n = 0; n <= 17; n++) begin
            @(negedge clk);
            checks++;
            if (flg !== ((n % 8) == 0)) begin
                errors++; $display("FAIL flg n=%0d got=%b exp=%b", n, flg, (n % 8) == 0);
            end
        end
    endtask

    task automatic test_blink();
        do_reset(2'b01, 4'b0010);
        for (int n = 0; n <= 33; n++) begin
            logic el;
            @(negedge clk);
            el = (n == 0) ? 1'b0 : exp_blink(n - 1);
            checks++;
            if (phase[0] !== exp_blink(n)) begin
                errors++; $display("FAIL blink_phase0 n=%0d got=%b exp=%b", n, phase[0], exp_blink(n));
            end
            checks++;
            if (led[0] !== el) begin
                errors++; $display("FAIL blink_led0 n=%0d got=%b exp=%b", n, led[0], el);
            end
            checks++;
            if (led[1] !== 1'b0) begin
                errors++; $display("FAIL blink_led1 n=%0d got=%b exp=0", n, led[1]);
            end
        end
    endtask

    task automatic test_burst();
        do_reset(2'b10, 4'b1100);
        for (int n = 0; n <= 63; n++) begin
            logic el;
            @(negedge clk);
            el = (n == 0) ? 1'b0 : exp_burst(n - 1);
            checks++;
            if (phase[1] !== exp_burst(n)) begin
                errors++; $display("FAIL burst_phase1 n=%0d got=%b exp=%b", n, phase[1], exp_burst(n));
            end
            checks++;
            if (led[1] !== el) begin
                errors++; $display("FAIL burst_led1 n=%0d got=%b exp=%b", n, led[1], el);
            end
            checks++;
            if (led[0] !== 1'b0) begin
                errors++; $display("FAIL burst_led0 n=%0d got=%b exp=0", n, led[0]);
            end
        end
    endtask

    task automatic test_en_drop();
        logic p0_prev;
        p0_prev = 1'b0;
        do_reset(2'b11, 4'b1110);
        for (int n = 0; n <= 23; n++) begin
            logic p0;
            logic l0;
            logic l1;
            @(negedge clk);
            if (n <= 2)      p0 = exp_blink(n);
            else if (n <= 7) p0 = 1'b0;
            else             p0 = exp_blink(n - 8);
            l0 = (n == 0 || n == 3) ? 1'b0 : p0_prev;
            l1 = (n == 0) ? 1'b0 : exp_burst(n - 1);
            checks++;
            if (phase[0] !== p0) begin
                errors++; $display("FAIL endrop_phase0 n=%0d got=%b exp=%b", n, phase[0], p0);
            end
            checks++;
            if (led[0] !== l0) begin
                errors++; $display("FAIL endrop_led0 n=%0d got=%b exp=%b", n, led[0], l0);
            end
            checks++;
            if (led[1] !== l1) begin
                errors++; $display("FAIL endrop_led1 n=%0d got=%b exp=%b", n, led[1], l1);
            end
            p0_prev = p0;
            if (n == 2) en = 2'b10;
            if (n == 3) en = 2'b11;
        end
    endtask

    task automatic test_mode_switch();
        logic p_prev;
        p_prev = 1'b0;
        do_reset(2'b01, 4'b0011);
        for (int n = 0; n <= 80; n++) begin
            logic p;
            logic l;
            @(negedge clk);
            if (n <= 31)      p = exp_burst(n);
            else if (n <= 50) p = 1'b1;
            else if (n <= 55) p = 1'b0;
            else              p = exp_burst(n - 56);
            l = (n == 0) ? 1'b0 : p_prev;
            checks++;
            if (phase[0] !== p) begin
                errors++; $display("FAIL modesw_phase0 n=%0d got=%b exp=%b", n, phase[0], p);
            end
            checks++;
            if (led[0] !== l) begin
                errors++; $display("FAIL modesw_led0 n=%0d got=%b exp=%b", n, led[0], l);
            end
            p_prev = p;
            if (n == 31) mode_sel = 4'b0001;
            if (n == 50) mode_sel = 4'b0011;
        end
    endtask

    task automatic run_seq(input int nmax, input int rst_at);
        for (int n = 0; n <= nmax; n++) begin
            logic [1:0] ep;
            logic [1:0] el;
            @(negedge clk);
            ep = {exp_burst(n), exp_blink(n)};
            el = (n == 0) ? 2'b00 : {exp_burst(n - 1), exp_blink(n - 1)};
            checks++;
            if (phase !== ep) begin
                errors++; $display("FAIL seq_phase n=%0d got=%b exp=%b", n, phase, ep);
            end
            checks++;
            if (led !== el) begin
                errors++; $display("FAIL seq_led n=%0d got=%b exp=%b", n, led, el);
            end
            checks++;
            if (flg !== ((n % 8) == 0)) begin
                errors++; $display("FAIL seq_flg n=%0d got=%b exp=%b", n, flg, (n % 8) == 0);
            end
            if (n == rst_at) begin
                #2 rst = 1'b1;
                #1;
                checks++;
                if ({led, phase, flg} !== 5'b0) begin
                    errors++; $display("FAIL async_rst n=%0d got led=%b phase=%b flg=%b exp all 0",
                                       n, led, phase, flg);
                end
                @(negedge clk);
                rst = 1'b0;
            end
        end
    endtask

    task automatic test_back_to_back();
        do_reset(2'b11, 4'b1110);
        run_seq(16, 16);
        run_seq(17, 17);
        run_seq(40, -1);
    endtask

    initial begin
        rst      = 1'b1;
        en       = 2'b00;
        mode_sel = 4'b0000;
        test_reset();
        test_prescaler();
        test_blink();
        test_burst();
        test_en_drop();
        test_mode_switch();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
